pll_lock_sequencer: RTL and testbench

//  Controller for the on-chip PLL in the clock-generation path.
//  - Runs on the free-running reference clock and drives the PLL reset.
//  - Watches the PLL lock output, with a lock timeout and a bounded retry count.
//  - Holds the design reset request until lock has been stable for a set time.
//  - Re-sequences the PLL on loss of lock. Its reset output feeds the per-domain reset shifters.

---
 rtl/pll_lock_sequencer.sv | 250 +++++++++++++++++++++++++
 tb/tb_pll_lock_sequencer.sv | 261 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/pll_lock_sequencer.sv
// ---------------------------------------------------------------------------
// pll_lock_sequencer
//
// Purpose:
//   Brings up the on-chip PLL from the free-running reference clock. It
//   pulses the PLL reset, waits for lock with a timeout, and requires lock
//   to stay stable for a set time before it releases the design reset
//   request. A failed attempt (timeout or lock dropping while stable) causes
//   a retry. After a bounded number of retries it parks in a terminal FAIL
//   state. Losing lock while running re-sequences the PLL from the start.
//
// Optional feature (compile-time macro PLL_SEQ_LOSS_CNT_EN):
//   defined   - o_loss_cnt counts lock losses seen in RUN, saturating.
//   undefined - no counter logic; o_loss_cnt is tied to 0.
//   The port list is the same in both builds.
//
// Ports:
//   i_clk       in   1      reference clock, free-running
//   i_rst       in   1      synchronous reset, active-high
//   i_locked    in   1      PLL lock, asynchronous (2-flop synchronised)
//   o_pll_rst   out  1      PLL reset, active-high
//   o_rst       out  1      design reset request, active-high
//   o_ready     out  1      high only in RUN
//   o_fail      out  1      sticky failure flag, high only in FAIL
//   o_loss_cnt  out  CNT_W  lock losses while in RUN (saturating)
//
// Timing:
//   All outputs are registered from the next state, so a state change is
//   visible on the outputs the cycle after the condition that caused it.
//   i_locked reaches the FSM (locked_s) two cycles after it is sampled.
// ---------------------------------------------------------------------------
module pll_lock_sequencer #(
    parameter int RST_CYCLES    = 16,
    parameter int LOCK_TIMEOUT  = 65535,
    parameter int STABLE_CYCLES = 1024,
    parameter int MAX_RETRIES   = 3,
    parameter int CNT_W         = 8
) (
    input  logic             i_clk,
    input  logic             i_rst,
    input  logic             i_locked,
    output logic             o_pll_rst,
    output logic             o_rst,
    output logic             o_ready,
    output logic             o_fail,
    output logic [CNT_W-1:0] o_loss_cnt
);

    // -----------------------------------------------------------------------
    // FSM encoding
    // -----------------------------------------------------------------------
    localparam logic [2:0] ST_RESET  = 3'd0;
    localparam logic [2:0] ST_WAIT   = 3'd1;
    localparam logic [2:0] ST_STABLE = 3'd2;
    localparam logic [2:0] ST_RUN    = 3'd3;
    localparam logic [2:0] ST_FAIL   = 3'd4;

    // -----------------------------------------------------------------------
    // Cycle counter sizing: large enough for the longest phase, so it never
    // wraps. Every phase compares against its own last-cycle value.
    // -----------------------------------------------------------------------
    localparam int CNT_MAX_A = (RST_CYCLES > LOCK_TIMEOUT) ? RST_CYCLES : LOCK_TIMEOUT;
    localparam int CNT_MAX   = (CNT_MAX_A > STABLE_CYCLES) ? CNT_MAX_A : STABLE_CYCLES;
    localparam int CW        = $clog2(CNT_MAX + 1);

    // The WAIT_LOCK cycle that first sees locked_s=1 is the first of the
    // STABLE_CYCLES consecutive lock cycles, so STABLE itself lasts
    // STABLE_CYCLES-1 cycles (counter 0 .. STABLE_CYCLES-2). With
    // STABLE_CYCLES=1 the STABLE state is skipped entirely.
    localparam int STB_LAST_I = (STABLE_CYCLES >= 2) ? (STABLE_CYCLES - 2) : 0;

    localparam logic [CW-1:0] RST_LAST = CW'(RST_CYCLES - 1);
    localparam logic [CW-1:0] TMO_LAST = CW'(LOCK_TIMEOUT - 1);
    localparam logic [CW-1:0] STB_LAST = CW'(STB_LAST_I);
    localparam logic [CW-1:0] CNT_ONE  = CW'(1);
    localparam logic [7:0]    MAX_RET  = 8'(MAX_RETRIES);

    // -----------------------------------------------------------------------
    // Lock synchroniser
    // -----------------------------------------------------------------------
    logic [1:0] sync_q;
    logic       locked_s;

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            sync_q <= 2'b00;
        end else begin
            sync_q <= {sync_q[0], i_locked};
        end
    end

    assign locked_s = sync_q[1];

    // -----------------------------------------------------------------------
    // State, counter and retry registers
    // -----------------------------------------------------------------------
    logic [2:0]    state_q, state_d;
    logic [CW-1:0] cnt_q, cnt_d;
    logic [7:0]    retries_q, retries_d;
    logic          fail_attempt;

    always_comb begin
        state_d      = state_q;
        cnt_d        = cnt_q + CNT_ONE;
        retries_d    = retries_q;
        fail_attempt = 1'b0;

        case (state_q)
            ST_RESET: begin
                if (cnt_q == RST_LAST) begin
                    state_d = ST_WAIT;
                    cnt_d   = '0;
                end
            end

            ST_WAIT: begin
                // Lock has priority over the timeout on the same cycle.
                if (locked_s) begin
                    cnt_d = '0;
                    if (STABLE_CYCLES == 1) begin
                        state_d   = ST_RUN;
                        retries_d = '0;
                    end else begin
                        state_d = ST_STABLE;
                    end
                end else if (cnt_q == TMO_LAST) begin
                    fail_attempt = 1'b1;
                end
            end

            ST_STABLE: begin
                if (!locked_s) begin
                    fail_attempt = 1'b1;
                end else if (cnt_q == STB_LAST) begin
                    state_d   = ST_RUN;
                    cnt_d     = '0;
                    retries_d = '0;
                end
            end

            ST_RUN: begin
                // Counter is idle here; hold it at zero so it cannot wrap.
                cnt_d = '0;
                if (!locked_s) begin
                    state_d = ST_RESET;
                end
            end

            ST_FAIL: begin
                cnt_d = '0;
            end

            default: begin
                state_d = ST_RESET;
                cnt_d   = '0;
            end
        endcase

        // A failed attempt either retries from RESET or gives up. The retry
        // budget is checked before incrementing, so MAX_RETRIES failures are
        // tolerated and the next one is terminal.
        if (fail_attempt) begin
            cnt_d = '0;
            if (retries_q == MAX_RET) begin
                state_d = ST_FAIL;
            end else begin
                retries_d = retries_q + 8'd1;
                state_d   = ST_RESET;
            end
        end
    end

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            state_q   <= ST_RESET;
            cnt_q     <= '0;
            retries_q <= '0;
        end else begin
            state_q   <= state_d;
            cnt_q     <= cnt_d;
            retries_q <= retries_d;
        end
    end

    // -----------------------------------------------------------------------
    // Registered outputs, decoded from the next state so they line up with
    // state_q after the clock edge.
    // -----------------------------------------------------------------------
    logic pll_rst_d, rst_d, ready_d, fail_d;
    logic pll_rst_q, rst_q, ready_q, fail_q;

    always_comb begin
        pll_rst_d = (state_d == ST_RESET) || (state_d == ST_FAIL);
        rst_d     = (state_d != ST_RUN);
        ready_d   = (state_d == ST_RUN);
        fail_d    = (state_d == ST_FAIL);
    end

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            pll_rst_q <= 1'b1;
            rst_q     <= 1'b1;
            ready_q   <= 1'b0;
            fail_q    <= 1'b0;
        end else begin
            pll_rst_q <= pll_rst_d;
            rst_q     <= rst_d;
            ready_q   <= ready_d;
            fail_q    <= fail_d;
        end
    end

    assign o_pll_rst = pll_rst_q;
    assign o_rst     = rst_q;
    assign o_ready   = ready_q;
    assign o_fail    = fail_q;

    // -----------------------------------------------------------------------
    // Lock-loss counter (optional)
    // -----------------------------------------------------------------------
`ifdef PLL_SEQ_LOSS_CNT_EN
    localparam logic [CNT_W-1:0] LOSS_ONE = CNT_W'(1);

    logic             loss_evt;
    logic [CNT_W-1:0] loss_cnt_q, loss_cnt_d;

    assign loss_evt = (state_q == ST_RUN) && !locked_s;

    always_comb begin
        loss_cnt_d = loss_cnt_q;
        // Saturate at all-ones; never wrap back to zero.
        if (loss_evt && (loss_cnt_q != {CNT_W{1'b1}})) begin
            loss_cnt_d = loss_cnt_q + LOSS_ONE;
        end
    end

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            loss_cnt_q <= '0;
        end else begin
            loss_cnt_q <= loss_cnt_d;
        end
    end

    assign o_loss_cnt = loss_cnt_q;
`else
    assign o_loss_cnt = '0;
`endif

endmodule

// File: tb/tb_pll_lock_sequencer.sv
// ---------------------------------------------------------------------------
// tb_pll_lock_sequencer
//
// A per-cycle stimulus table (i_rst, i_locked) is built from directed
// segments followed by a randomised soak. A phase-level reference model
// walks that table and pushes every expected output change, tagged with the
// clock edge at which it must appear, into exp_q. A driver replays the
// table; an independent monitor pops exp_q whenever the DUT outputs change
// and compares edge and value.
// ---------------------------------------------------------------------------
module tb_pll_lock_sequencer;

    localparam int RST_C = 4;
    localparam int TMO   = 20;
    localparam int STB   = 8;
    localparam int MAXR  = 2;
    localparam int CW    = 2;
    localparam int LOSS_MAX = (1 << CW) - 1;

    localparam int NMAX = 2000;
    localparam int OW   = 4 + CW;
    localparam int EW   = 32 + OW;

    typedef enum int {PH_RESET, PH_WAIT, PH_STABLE, PH_RUN, PH_FAIL} ph_e;

    // -----------------------------------------------------------------------
    // Clock / DUT
    // -----------------------------------------------------------------------
    logic          clk = 1'b0;
    logic          i_rst;
    logic          i_locked;
    logic          o_pll_rst;
    logic          o_rst;
    logic          o_ready;
    logic          o_fail;
    logic [CW-1:0] o_loss_cnt;

    always #5 clk = ~clk;

    pll_lock_sequencer #(
        .RST_CYCLES   (RST_C),
        .LOCK_TIMEOUT (TMO),
        .STABLE_CYCLES(STB),
        .MAX_RETRIES  (MAXR),
        .CNT_W        (CW)
    ) dut (
        .i_clk     (clk),
        .i_rst     (i_rst),
        .i_locked  (i_locked),
        .o_pll_rst (o_pll_rst),
        .o_rst     (o_rst),
        .o_ready   (o_ready),
        .o_fail    (o_fail),
        .o_loss_cnt(o_loss_cnt)
    );

    // -----------------------------------------------------------------------
    // Stimulus table and scoreboard state
    // -----------------------------------------------------------------------
    bit              rst_a [NMAX];
    bit              lk_a  [NMAX];
    int              n_cyc = 0;
    logic [EW-1:0]   exp_q [$];
    logic [OW-1:0]   last_out;
    bit              have_last = 1'b0;
    bit              go = 1'b0;
    int              total = 0;
    int              bad = 0;

    task automatic add(input bit r, input bit l, input int len);
        for (int i = 0; i < len; i++) begin
            if (n_cyc < NMAX) begin
                rst_a[n_cyc] = r;
                lk_a[n_cyc]  = l;
                n_cyc++;
            end
        end
    endtask

    // Synchronised lock as seen by the FSM at edge e: i_locked from two
    // edges earlier, forced low while the synchroniser is being reset.
    function automatic bit ls_at(input int e);
        if (e < 2) return 1'b0;
        if (rst_a[e-1] || rst_a[e-2]) return 1'b0;
        return lk_a[e-2];
    endfunction

    task automatic emit(input int e, input ph_e ph, input int loss);
        logic [3:0]    f;
        logic [CW-1:0] lc;
        logic [OW-1:0] o;
        case (ph)
            PH_RESET: f = 4'b1100;
            PH_RUN:   f = 4'b0010;
            PH_FAIL:  f = 4'b1101;
            default:  f = 4'b0100;
        endcase
`ifdef PLL_SEQ_LOSS_CNT_EN
        lc = CW'(loss);
`else
        lc = '0;
`endif
        o = {f, lc};
        if (!have_last || o != last_out) begin
            exp_q.push_back({32'(e), o});
            last_out  = o;
            have_last = 1'b1;
        end
    endtask

    // Phase-level reference: each phase has a length in edges counted from
    // the edge that entered it; k is the 1-based edge index within it.
    task automatic build_expect();
        ph_e ph      = PH_RESET;
        int  at      = -1;
        int  retries = 0;
        int  loss    = 0;
        int  k;
        bit  moved;
        bit  failed;
        for (int e = 0; e < n_cyc; e++) begin
            moved  = 1'b0;
            failed = 1'b0;
            k      = e - at;
            if (rst_a[e]) begin
                ph = PH_RESET; retries = 0; loss = 0; moved = 1'b1;
            end else begin
                case (ph)
                    PH_RESET: if (k == RST_C) begin ph = PH_WAIT; moved = 1'b1; end
                    PH_WAIT: begin
                        if (ls_at(e)) begin
                            if (STB == 1) begin ph = PH_RUN; retries = 0; end
                            else ph = PH_STABLE;
                            moved = 1'b1;
                        end else if (k == TMO) begin
                            failed = 1'b1;
                        end
                    end
                    PH_STABLE: begin
                        if (!ls_at(e)) failed = 1'b1;
                        else if (k == STB - 1) begin ph = PH_RUN; retries = 0; moved = 1'b1; end
                    end
                    PH_RUN: begin
                        if (!ls_at(e)) begin
                            if (loss < LOSS_MAX) loss++;
                            ph = PH_RESET; moved = 1'b1;
                        end
                    end
                    default: ;
                endcase
                if (failed) begin
                    moved = 1'b1;
                    if (retries == MAXR) ph = PH_FAIL;
                    else begin retries++; ph = PH_RESET; end
                end
            end
            if (moved) begin
                at = e;
                emit(e, ph, loss);
            end
        end
    endtask

    // -----------------------------------------------------------------------
    // Stimulus construction
    // -----------------------------------------------------------------------
    initial begin
        bit lv;
        i_rst    = 1'b1;
        i_locked = 1'b0;

        // Bring-up: lock arrives ~10 cycles after reset release.
        add(1, 0, 3);
        add(0, 0, 10 + $urandom_range(0, 3));
        add(0, 1, 40);
        // Five losses in RUN (counter saturates).
        for (int i = 0; i < 5; i++) begin
            add(0, 0, $urandom_range(1, 4));
            add(0, 1, 40);
        end
        // Lock never returns: three timeouts, then FAIL; late lock ignored.
        add(0, 0, 120);
        add(0, 1, 20);
        // One-cycle glitch after 5 STABLE cycles, clean lock, then timeouts.
        add(1, 0, 2);
        add(0, 1, 8);
        add(0, 0, 1);
        add(0, 1, 60);
        add(0, 0, 120);
        // Reset while in WAIT_LOCK with one retry used, then full budget.
        add(1, 0, 2);
        add(0, 0, 33);
        add(1, 0, 1);
        add(0, 0, 100);
        // Randomised soak.
        add(1, 0, 2);
        lv = 1'b1;
        while (n_cyc < NMAX - 300) begin
            if ($urandom_range(0, 19) == 0) add(1, 0, $urandom_range(1, 2));
            add(0, lv, lv ? $urandom_range(5, 50) : $urandom_range(1, 12));
            lv = !lv;
        end

        build_expect();
        go = 1'b1;
    end

    // -----------------------------------------------------------------------
    // Driver: inputs change on the falling edge before the edge they apply to.
    // -----------------------------------------------------------------------
    initial begin
        wait (go);
        for (int c = 0; c < n_cyc; c++) begin
            @(negedge clk);
            i_rst    = rst_a[c];
            i_locked = lk_a[c];
        end
    end

    // -----------------------------------------------------------------------
    // Monitor / scoreboard
    // -----------------------------------------------------------------------
    initial begin
        logic [OW-1:0] prev;
        logic [OW-1:0] act;
        logic [EW-1:0] exp_e;
        prev = '0;
        wait (go);
        @(negedge clk);
        for (int e = 0; e < n_cyc; e++) begin
            @(posedge clk);
            #1;
            act = {o_pll_rst, o_rst, o_ready, o_fail, o_loss_cnt};
            if (e == 0 || act !== prev) begin
                total++;
                if (exp_q.size() == 0) begin
                    bad++;
                    $display("FAIL unexpected_change edge=%0d got=%b want=no_change", e, act);
                end else begin
                    exp_e = exp_q.pop_front();
                    if (exp_e[EW-1:OW] !== 32'(e) || exp_e[OW-1:0] !== act) begin
                        bad++;
                        $display("FAIL out_event edge=%0d got=%b want_edge=%0d want=%b",
                                 e, act, exp_e[EW-1:OW], exp_e[OW-1:0]);
                    end
                end
            end
            prev = act;
        end
        total++;
        if (exp_q.size() != 0) begin
            bad++;
            exp_e = exp_q[0];
            $display("FAIL missing_events left=%0d next_edge=%0d next_want=%b",
                     exp_q.size(), exp_e[EW-1:OW], exp_e[OW-1:0]);
        end
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
